// File: rtl/lbdr_param_if.sv
// Purpose : FIFO-head view presented to the LBDR unit (flit at head of the input FIFO).
// Ports   : empty, flit_id, dst_addr ({y,x}), rd.
//           The master is the input FIFO side; the slave is lbdr_param.
interface lbdr_param_if #(
  parameter int X_W = 2,
  parameter int Y_W = 2
);
  logic                 empty;
  logic [2:0]           flit_id;
  logic [X_W+Y_W-1:0]   dst_addr;
  logic                 rd;

  modport master (output empty, flit_id, dst_addr, rd);
  modport slave  (input  empty, flit_id, dst_addr, rd);
endinterface

// File: rtl/lbdr_param.sv
// Purpose : registered LBDR route computation; holds a one-hot N/E/W/S/L request per packet.
// Latency : 1 cycle header->ports, 1 cycle tail-dequeue->ports cleared.
// Backpr. : none applied; the FIFO owner dequeues via rd, only the tail with rd=1 releases.
// Ports   : clk, rst (sync, active-high); fifo (lbdr_param_if.slave); cur_addr_rst/Rxy_rst/Cx_rst
//           reset-time programming; cfg_we/cfg_rxy/cfg_cx run-time reprogramming, cfg_busy while
//           an update is deferred; Nport/Eport/Wport/Sport/Lport requests; route_err.
// Option  : define LBDR_ROUTE_ERR_EN to build the sticky unroutable-header flag (else tied 0).
module lbdr_param #(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  lbdr_param_if.slave        fifo,
  input  logic [X_W+Y_W-1:0] cur_addr_rst,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_rxy,
  input  logic [3:0]         cfg_cx,
  output logic               cfg_busy,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               route_err
);
  localparam int AW = X_W + Y_W;

  typedef enum logic {IDLE, ROUTED} state_t;

  state_t         state;
  logic [AW-1:0]  cur_addr;
  logic [7:0]     rxy, rxy_hold;
  logic [3:0]     cx, cx_hold;
  logic           cfg_pend;
  logic [4:0]     port_q;     // {N,E,W,S,L}

  // ---------------- route computation ----------------
  logic [AW-1:0]  dst;
  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1;
  logic           rne, rnw, ren, res, rwn, rws, rse, rsw;
  logic           cn, ce, cw, cs;
  logic [4:0]     route_vec;
  logic           is_hdr, is_tail_rd;

  assign dst   = fifo.dst_addr;
  assign x_cur = cur_addr[X_W-1:0];
  assign y_cur = cur_addr[AW-1:X_W];
  assign x_dst = dst[X_W-1:0];
  assign y_dst = dst[AW-1:X_W];

  // y grows southward, so a smaller row index lies to the north
  assign n1 = (y_dst < y_cur);
  assign s1 = (y_dst > y_cur);
  assign e1 = (x_dst > x_cur);
  assign w1 = (x_dst < x_cur);

  assign {rne, rnw, ren, res, rwn, rws, rse, rsw} = rxy;
  assign {cn, ce, cw, cs} = cx;

  assign route_vec[4] = cn & ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw));
  assign route_vec[3] = ce & ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res));
  assign route_vec[2] = cw & ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws));
  assign route_vec[1] = cs & ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw));
  assign route_vec[0] = ~n1 & ~e1 & ~w1 & ~s1;

  assign is_hdr     = ~fifo.empty & (fifo.flit_id == 3'b001);
  assign is_tail_rd = ~fifo.empty & (fifo.flit_id == 3'b100) & fifo.rd;

  // ---------------- packet FSM and configuration ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      port_q   <= '0;
      cur_addr <= cur_addr_rst;
      rxy      <= Rxy_rst;
      cx       <= Cx_rst;
      rxy_hold <= '0;
      cx_hold  <= '0;
      cfg_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_hdr) begin
            port_q <= route_vec;
            state  <= ROUTED;
          end
        end
        ROUTED: begin
          if (is_tail_rd) begin
            port_q <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Rxy/Cx never change under a live packet; writes made while ROUTED are parked
      // and applied in the first IDLE cycle. A header accepted at that same edge was
      // already routed above with the old values.
      if (state == ROUTED) begin
        if (cfg_we) begin
          rxy_hold <= cfg_rxy;
          cx_hold  <= cfg_cx;
          cfg_pend <= 1'b1;
        end
      end else if (cfg_we) begin
        rxy      <= cfg_rxy;
        cx       <= cfg_cx;
        cfg_pend <= 1'b0;
      end else if (cfg_pend) begin
        rxy      <= rxy_hold;
        cx       <= cx_hold;
        cfg_pend <= 1'b0;
      end
    end
  end

  assign {Nport, Eport, Wport, Sport, Lport} = port_q;
  assign cfg_busy = cfg_pend;

`ifdef LBDR_ROUTE_ERR_EN
  logic cfg_apply;
  logic err_q;

  assign cfg_apply = (state == IDLE) & (cfg_we | cfg_pend);

  // A dead-end header is judged against the pre-update tables, so it wins over
  // an update applied at the same edge.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((state == IDLE) && is_hdr && (route_vec == 5'b0))
      err_q <= 1'b1;
    else if (cfg_apply)
      err_q <= 1'b0;
  end

  assign route_err = err_q;
`else
  assign route_err = 1'b0;
`endif

endmodule

// File: tb/tb_lbdr_param.sv
module tb_lbdr_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef LBDR_ROUTE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // ---------------- DUT 0: 4x4 mesh ----------------
  lbdr_param_if #(.X_W(2), .Y_W(2)) f0 ();
  logic [3:0] cur0_rst;
  logic [7:0] rxy0_rst, cfg_rxy0;
  logic [3:0] cx0_rst, cfg_cx0;
  logic       cfg_we0;
  logic       busy0, n0, e0, w0, s0, l0, err0;

  lbdr_param #(.X_W(2), .Y_W(2)) u0 (
    .clk(clk), .rst(rst), .fifo(f0),
    .cur_addr_rst(cur0_rst), .Rxy_rst(rxy0_rst), .Cx_rst(cx0_rst),
    .cfg_we(cfg_we0), .cfg_rxy(cfg_rxy0), .cfg_cx(cfg_cx0),
    .cfg_busy(busy0),
    .Nport(n0), .Eport(e0), .Wport(w0), .Sport(s0), .Lport(l0),
    .route_err(err0)
  );

  // ---------------- DUT 1: 8x4 mesh ----------------
  lbdr_param_if #(.X_W(3), .Y_W(2)) f1 ();
  logic [4:0] cur1_rst;
  logic [7:0] rxy1_rst, cfg_rxy1;
  logic [3:0] cx1_rst, cfg_cx1;
  logic       cfg_we1;
  logic       busy1, n1, e1, w1, s1, l1, err1;

  lbdr_param #(.X_W(3), .Y_W(2)) u1 (
    .clk(clk), .rst(rst), .fifo(f1),
    .cur_addr_rst(cur1_rst), .Rxy_rst(rxy1_rst), .Cx_rst(cx1_rst),
    .cfg_we(cfg_we1), .cfg_rxy(cfg_rxy1), .cfg_cx(cfg_cx1),
    .cfg_busy(busy1),
    .Nport(n1), .Eport(e1), .Wport(w1), .Sport(s1), .Lport(l1),
    .route_err(err1)
  );

  // one clock edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flit0(input logic emp, input logic [2:0] id, input logic [3:0] d, input logic r);
    f0.empty = emp; f0.flit_id = id; f0.dst_addr = d; f0.rd = r;
  endtask

  initial begin
    // ---- reset: node (1,1), all turns allowed, all links up ----
    rst = 1'b1;
    cur0_rst = 4'h5; rxy0_rst = 8'hFF; cx0_rst = 4'hF;
    cfg_we0 = 1'b0; cfg_rxy0 = 8'h00; cfg_cx0 = 4'h0;
    flit0(1'b0, 3'b001, 4'h5, 1'b0);   // header present during reset must be ignored
    cur1_rst = 5'h0B; rxy1_rst = 8'h20; cx1_rst = 4'hF;
    cfg_we1 = 1'b0; cfg_rxy1 = 8'h00; cfg_cx1 = 4'h0;
    f1.empty = 1'b1; f1.flit_id = 3'b000; f1.dst_addr = 5'h00; f1.rd = 1'b0;
    step(); step();
    chk("rst_ports", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    chk("rst_busy",  {7'b0, busy0}, 8'h00);
    chk("rst_err",   {7'b0, err0},  8'h00);
    chk("rst_ports_w3", {3'b0, n1, e1, w1, s1, l1}, 8'h00);
    rst = 1'b0;
    flit0(1'b1, 3'b000, 4'h0, 1'b0);
    step();

    // ---- local delivery: dst == cur ----
    flit0(1'b0, 3'b001, 4'h5, 1'b0);
    step();
    chk("local_hdr", {3'b0, n0, e0, w0, s0, l0}, 8'h01);
    chk("local_err", {7'b0, err0}, 8'h00);
    flit0(1'b0, 3'b010, 4'hA, 1'b1);   // body with changing dst: ignored
    step();
    chk("local_body", {3'b0, n0, e0, w0, s0, l0}, 8'h01);
    flit0(1'b0, 3'b001, 4'h0, 1'b0);   // stray header while routed: ignored
    step();
    chk("local_hdr_in_routed", {3'b0, n0, e0, w0, s0, l0}, 8'h01);
    flit0(1'b0, 3'b100, 4'h0, 1'b0);   // tail not yet dequeued
    step();
    chk("tail_no_rd", {3'b0, n0, e0, w0, s0, l0}, 8'h01);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    chk("tail_release", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    flit0(1'b0, 3'b010, 4'h5, 1'b1);   // body in IDLE: ignored
    step();
    chk("body_in_idle", {3'b0, n0, e0, w0, s0, l0}, 8'h00);

    // ---- reprogram in IDLE: Rse only, dst (2,2) goes south ----
    flit0(1'b1, 3'b000, 4'h0, 1'b0);
    cfg_we0 = 1'b1; cfg_rxy0 = 8'h02; cfg_cx0 = 4'hF;
    step();
    cfg_we0 = 1'b0;
    chk("idle_cfg_busy", {7'b0, busy0}, 8'h00);
    flit0(1'b0, 3'b001, 4'hA, 1'b0);
    step();
    chk("se_via_south", {3'b0, n0, e0, w0, s0, l0}, 8'h02);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    chk("se_release", {3'b0, n0, e0, w0, s0, l0}, 8'h00);

    // ---- reprogram in IDLE: Res only, same header goes east ----
    flit0(1'b1, 3'b000, 4'h0, 1'b0);
    cfg_we0 = 1'b1; cfg_rxy0 = 8'h10; cfg_cx0 = 4'hF;
    step();
    cfg_we0 = 1'b0;
    flit0(1'b0, 3'b001, 4'hA, 1'b0);
    step();
    chk("se_via_east", {3'b0, n0, e0, w0, s0, l0}, 8'h08);

    // ---- cfg write while routed is deferred ----
    flit0(1'b0, 3'b010, 4'h0, 1'b0);
    cfg_we0 = 1'b1; cfg_rxy0 = 8'h10; cfg_cx0 = 4'h0;
    step();
    cfg_we0 = 1'b0;
    chk("defer_busy", {7'b0, busy0}, 8'h01);
    chk("defer_ports", {3'b0, n0, e0, w0, s0, l0}, 8'h08);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    chk("defer_tail_ports", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    chk("defer_busy_at_idle", {7'b0, busy0}, 8'h01);
    flit0(1'b1, 3'b000, 4'h0, 1'b0);
    step();
    chk("defer_busy_fall", {7'b0, busy0}, 8'h00);

    // ---- all links down: north header is unroutable ----
    flit0(1'b0, 3'b001, 4'h1, 1'b0);
    step();
    chk("dead_end_ports", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    chk("dead_end_err", {7'b0, err0}, {7'b0, EXP_ERR});
    flit0(1'b0, 3'b001, 4'h5, 1'b0);   // still ROUTED: a local header must not route
    step();
    chk("dead_end_holds", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    chk("dead_end_err_sticky", {7'b0, err0}, {7'b0, EXP_ERR});
    flit0(1'b1, 3'b000, 4'h0, 1'b0);
    cfg_we0 = 1'b1; cfg_rxy0 = 8'h10; cfg_cx0 = 4'hF;
    step();
    cfg_we0 = 1'b0;
    chk("err_clear_on_cfg", {7'b0, err0}, 8'h00);

    // ---- back-to-back packets: east then west ----
    flit0(1'b0, 3'b001, 4'hA, 1'b0);
    step();
    chk("b2b_first", {3'b0, n0, e0, w0, s0, l0}, 8'h08);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    chk("b2b_gap", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    flit0(1'b0, 3'b001, 4'h4, 1'b0);
    step();
    chk("b2b_west", {3'b0, n0, e0, w0, s0, l0}, 8'h04);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();

    // ---- reset mid-packet with a pending update ----
    flit0(1'b0, 3'b001, 4'hA, 1'b0);
    step();
    chk("pre_rst_east", {3'b0, n0, e0, w0, s0, l0}, 8'h08);
    flit0(1'b0, 3'b010, 4'h0, 1'b0);
    cfg_we0 = 1'b1; cfg_rxy0 = 8'hFF; cfg_cx0 = 4'hF;
    step();
    cfg_we0 = 1'b0;
    chk("pre_rst_busy", {7'b0, busy0}, 8'h01);
    rxy0_rst = 8'h02;
    rst = 1'b1;
    step();
    chk("mid_rst_ports", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    chk("mid_rst_busy", {7'b0, busy0}, 8'h00);
    rst = 1'b0;
    cur0_rst = 4'hA;                    // must not be picked up outside reset
    flit0(1'b0, 3'b100, 4'h0, 1'b1);    // orphan tail: ignored
    step();
    chk("orphan_tail", {3'b0, n0, e0, w0, s0, l0}, 8'h00);
    flit0(1'b0, 3'b001, 4'hA, 1'b0);
    step();
    chk("post_rst_reload", {3'b0, n0, e0, w0, s0, l0}, 8'h02);
    flit0(1'b0, 3'b100, 4'h0, 1'b1);
    step();
    flit0(1'b1, 3'b000, 4'h0, 1'b0);

    // ---- wider X: node (3,1), dst (7,0), Ren only -> east ----
    f1.empty = 1'b0; f1.flit_id = 3'b001; f1.dst_addr = 5'h07;
    step();
    chk("w3_ne_east", {3'b0, n1, e1, w1, s1, l1}, 8'h08);
    f1.flit_id = 3'b100; f1.rd = 1'b1;
    step();
    chk("w3_release", {3'b0, n1, e1, w1, s1, l1}, 8'h00);
    f1.empty = 1'b1; f1.rd = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lbdr_param.md
# lbdr_param

Parametrised, registered Logic-Based Distributed Routing (LBDR) unit for the mesh NoC router input port. It decodes the header flit at the head of the input FIFO into a one-hot output-port request (N/E/W/S/L) and holds that request until the packet's tail flit is dequeued. It supersedes the fixed 4x4-mesh LBDR:

- Mesh coordinate widths are parameters.
- Routing and connectivity bits can be reprogrammed at run time, with packet-safe update timing.
- An optional unroutable-header error flag is provided.

## Interface
Parameters:
- X_W, 2, bits of X coordinate (mesh columns = 2^X_W)
- Y_W, 2, bits of Y coordinate (mesh rows = 2^Y_W)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- empty  in  1  input FIFO empty; flit fields are invalid when 1
- flit_id  in  3  flit type at FIFO head: 3'b001 header, 3'b010 body, 3'b100 tail; other codes are ignored
- dst_addr  in  X_W+Y_W  destination of the head flit, {y, x} with x in the LSBs
- rd  in  1  FIFO read strobe; head flit is consumed this cycle
- cur_addr_rst  in  X_W+Y_W  node address, loaded on reset
- Rxy_rst  in  8  routing bits loaded on reset, {Rne,Rnw,Ren,Res,Rwn,Rws,Rse,Rsw}
- Cx_rst  in  4  connectivity bits loaded on reset, {Cn,Ce,Cw,Cs}
- cfg_we  in  1  one-cycle request to load cfg_rxy/cfg_cx
- cfg_rxy  in  8  new Rxy value
- cfg_cx  in  4  new Cx value
- cfg_busy  out  1  a configuration update is pending
- Nport, Eport, Wport, Sport, Lport  out  1 each  registered port request
- route_err  out  1  sticky unroutable-header flag (see Configuration)

## Operation
- Internal registers:
  - cur_addr, Rxy, Cx
  - state: IDLE or ROUTED
  - 5-bit port register
  - cfg_pend, plus holding registers for the pending Rxy/Cx
- Reset loads:
  - cur_addr = cur_addr_rst, Rxy = Rxy_rst, Cx = Cx_rst
  - state = IDLE, all port outputs = 0, cfg_pend = 0, cfg_busy = 0, route_err = 0
- Comparators, unsigned, with y increasing southward:
  - N1 = y_dst < y_cur
  - S1 = y_dst > y_cur
  - E1 = x_dst > x_cur
  - W1 = x_dst < x_cur
- Port equations:
  - N = Cn & (N1&!E1&!W1 | N1&E1&Rne | N1&W1&Rnw)
  - E = Ce & (E1&!N1&!S1 | E1&N1&Ren | E1&S1&Res)
  - W = Cw & (W1&!N1&!S1 | W1&N1&Rwn | W1&S1&Rws)
  - S = Cs & (S1&!E1&!W1 | S1&E1&Rse | S1&W1&Rsw)
  - L = !N1 & !E1 & !W1 & !S1
- State machine:
  - IDLE, with empty=0 and flit_id=001: register the port equations and go to ROUTED. rd is irrelevant to routing.
  - IDLE, body or tail flit at the head: ignore it and stay in IDLE with outputs 0.
  - ROUTED: hold the port register and ignore header, body and dst_addr changes.
  - ROUTED to IDLE: on empty=0 & flit_id=100 & rd=1, clear the port register.
- Configuration update:
  - cfg_we=1 in ROUTED: latch cfg_rxy/cfg_cx into the holding registers and set cfg_pend. A later cfg_we overwrites the held value (last write wins).
  - cfg_we=1 or cfg_pend=1 in IDLE: update Rxy/Cx at that edge and clear cfg_pend. A direct cfg_we takes priority over the held value.
  - A header accepted at the same edge is routed with the pre-update Rxy/Cx.
  - cur_addr changes only on reset.
- Reset mid-packet aborts the packet: outputs go to 0 at the next edge and the configuration reloads from the *_rst inputs.

## Timing
- Routing latency is 1 cycle: a header visible in cycle t gives valid ports in cycle t+1.
- Release latency is 1 cycle: tail consumed in cycle t gives outputs 0 in cycle t+1.
- Back-to-back packets: a header visible in cycle t+1 gives ports in cycle t+2, so there is exactly one cycle with all-zero outputs between packets.
- Outputs are at most one-hot in the normal case. L is one-hot by construction. Exactly one of N/E/W/S is set only when the Rxy/Cx programming is consistent.
- cfg_busy rises the cycle after a cfg_we in ROUTED and falls the cycle after the block returns to IDLE.

## Configuration
- Macro LBDR_ROUTE_ERR_EN, defined:
  - A header whose computed 5-bit vector is all zero sets route_err at the routing edge.
  - route_err stays set until rst or an applied configuration update.
  - The block still enters ROUTED with all-zero outputs and leaves on the tail as normal.
- Macro LBDR_ROUTE_ERR_EN, undefined:
  - route_err is constant 0 and no error logic is built.
  - All other behaviour is identical.

## Test plan
- X_W=Y_W=2, cur=0x5 (x1,y1), Rxy=0xFF, Cx=0xF. Header dst=0x5 -> Lport=1 one cycle later. Body flits keep Lport=1. Tail with rd=1 -> Lport=0 next cycle.
- Same node, dst=0xA (x2,y2), Rxy=0x02 (Rse=1, Res=0) -> Sport=1 only. After reprogramming in IDLE to Rxy=0x10 (Res=1, Rse=0), the same header -> Eport=1 only.
- cfg_we with cfg_cx=0x0 while ROUTED -> cfg_busy=1 and outputs unchanged. After the tail, Cx=0. The next header dst=0x1 -> no port. With LBDR_ROUTE_ERR_EN defined, route_err=1.
- Tail flit followed immediately by a header dst=0x4 -> ports 0 for exactly one cycle, then Wport=1.
- rst asserted mid-packet with Eport=1 -> all outputs 0 the next cycle and Rxy/Cx/cur_addr equal the *_rst inputs. A tail arriving after reset is ignored.
- X_W=3, Y_W=2, cur=0x0B (x3,y1), dst=0x07 (x7,y0), Rxy=0x20 (Ren=1) -> Eport=1, confirming coordinate width scaling.
